// File: rtl/load_store_queue_if.sv
// Dispatch, CDB snoop and LSU-side signals of the load/store queue.
//
// Handshake semantics:
//   - Dispatch: an op is accepted on a clock edge where disp_valid_i=1 and
//     lsq_full_o=0. lsq_full_o is registered, so a same-cycle pop never makes
//     room for that cycle's dispatch.
//   - LSU: the head is popped on a clock edge where lsu_read_i=1 and
//     lsu_instr_ready_o=1. lsu_read_i without ready is ignored.
// cdb_i[k] = {tag, value}. Tag 0 (NO_VAL) means the bus is idle.
interface load_store_queue_if #(
  parameter int DEPTH   = 8,
  parameter int NUM_CDB = 2,
  parameter int TAG_W   = 5
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                             disp_valid_i;
  logic                             disp_load_i;
  logic [TAG_W-1:0]                 disp_ld_tag_i;
  logic [TAG_W-1:0]                 disp_base_tag_i;
  logic [31:0]                      disp_base_val_i;
  logic [11:0]                      disp_offset_i;
  logic [TAG_W-1:0]                 disp_st_tag_i;
  logic [31:0]                      disp_st_val_i;
  logic                             lsq_full_o;
  logic [CW-1:0]                    lsq_count_o;
  logic [NUM_CDB-1:0][TAG_W+31:0]   cdb_i;
  logic                             lsu_read_i;
  logic                             lsu_empty_o;
  logic                             lsu_instr_ready_o;
  logic                             lsu_load_o;
  logic [TAG_W-1:0]                 lsu_ld_tag_o;
  logic [31:0]                      lsu_eff_addr_o;
  logic [31:0]                      lsu_st_data_o;

  // Queue side
  modport slave (
    input  disp_valid_i, disp_load_i, disp_ld_tag_i, disp_base_tag_i,
           disp_base_val_i, disp_offset_i, disp_st_tag_i, disp_st_val_i,
           cdb_i, lsu_read_i,
    output lsq_full_o, lsq_count_o, lsu_empty_o, lsu_instr_ready_o,
           lsu_load_o, lsu_ld_tag_o, lsu_eff_addr_o, lsu_st_data_o
  );

  // Dispatch / CDB / LSU side
  modport master (
    output disp_valid_i, disp_load_i, disp_ld_tag_i, disp_base_tag_i,
           disp_base_val_i, disp_offset_i, disp_st_tag_i, disp_st_val_i,
           cdb_i, lsu_read_i,
    input  lsq_full_o, lsq_count_o, lsu_empty_o, lsu_instr_ready_o,
           lsu_load_o, lsu_ld_tag_o, lsu_eff_addr_o, lsu_st_data_o
  );
endinterface

// File: rtl/load_store_queue.sv
// In-order load/store queue. Operands are resolved by snooping the CDBs,
// the effective address is formed one cycle after the base is known, and the
// oldest op is offered to the data-memory unit. No reordering of any kind.
module load_store_queue #(
  parameter int DEPTH   = 8,
  parameter int NUM_CDB = 2,
  parameter int TAG_W   = 5
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  load_store_queue_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [TAG_W-1:0] NO_VAL = '0;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [DEPTH-1:0] ent_valid, ent_load, ent_base_rdy, ent_addr_rdy, ent_st_rdy;
  logic [TAG_W-1:0] ent_ld_tag   [DEPTH];
  logic [TAG_W-1:0] ent_base_tag [DEPTH];
  logic [TAG_W-1:0] ent_st_tag   [DEPTH];
  logic [31:0]      ent_base_val [DEPTH];
  logic [31:0]      ent_addr     [DEPTH];
  logic [31:0]      ent_st_val   [DEPTH];
  logic [11:0]      ent_off      [DEPTH];

  logic [AW:0]   head_q, tail_q, head_nxt, tail_nxt, count;
  logic [AW-1:0] head_idx, tail_idx;
  logic          full_q, head_age_q, hold_sel_q;
  logic [31:0]   hold_addr_q, hold_data_q;
  logic          empty, ready, do_disp, do_pop;
  logic [32:0]   disp_base_hit, disp_st_hit;
  logic [32:0]   base_hit [DEPTH];
  logic [32:0]   st_hit   [DEPTH];

  // {hit, value}; scanning downwards lets the lowest-numbered CDB win.
  function automatic logic [32:0] cdb_lookup(input logic [TAG_W-1:0] tag,
                                             input logic [NUM_CDB-1:0][TAG_W+31:0] cdb);
    logic [32:0] r;
    r = '0;
    for (int k = NUM_CDB - 1; k >= 0; k--)
      if (tag != NO_VAL && cdb[k][TAG_W+31:32] == tag) r = {1'b1, cdb[k][31:0]};
    return r;
  endfunction

  assign head_idx = head_q[AW-1:0];
  assign tail_idx = tail_q[AW-1:0];
  assign count    = tail_q - head_q;
  assign empty    = (count == '0);
  assign ready    = !empty && ent_valid[head_idx] && ent_addr_rdy[head_idx] &&
                    (ent_load[head_idx] || ent_st_rdy[head_idx]) && head_age_q;
  assign do_disp  = bus.disp_valid_i && !full_q;
  assign do_pop   = bus.lsu_read_i && ready;
  assign head_nxt = head_q + (AW+1)'(do_pop);
  assign tail_nxt = tail_q + (AW+1)'(do_disp);

  assign disp_base_hit = cdb_lookup(bus.disp_base_tag_i, bus.cdb_i);
  assign disp_st_hit   = cdb_lookup(bus.disp_st_tag_i, bus.cdb_i);

  for (genvar g = 0; g < DEPTH; g++) begin : g_snoop
    assign base_hit[g] = cdb_lookup(ent_base_tag[g], bus.cdb_i);
    assign st_hit[g]   = cdb_lookup(ent_st_tag[g], bus.cdb_i);
  end

  // Entry storage: dispatch write, CDB capture, address generation, pop.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_valid[i]    <= 1'b0;
        ent_load[i]     <= 1'b0;
        ent_base_rdy[i] <= 1'b0;
        ent_addr_rdy[i] <= 1'b0;
        ent_st_rdy[i]   <= 1'b0;
        ent_ld_tag[i]   <= '0;
        ent_base_tag[i] <= '0;
        ent_st_tag[i]   <= '0;
        ent_base_val[i] <= '0;
        ent_addr[i]     <= '0;
        ent_st_val[i]   <= '0;
        ent_off[i]      <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (do_disp && tail_idx == AW'(i)) begin
          ent_valid[i]    <= 1'b1;
          ent_load[i]     <= bus.disp_load_i;
          ent_ld_tag[i]   <= bus.disp_ld_tag_i;
          ent_off[i]      <= bus.disp_offset_i;
          ent_addr_rdy[i] <= 1'b0;
          ent_addr[i]     <= '0;
          ent_base_tag[i] <= bus.disp_base_tag_i;
          ent_base_rdy[i] <= (bus.disp_base_tag_i == NO_VAL) || disp_base_hit[32];
          ent_base_val[i] <= (bus.disp_base_tag_i == NO_VAL) ? bus.disp_base_val_i
                                                              : disp_base_hit[31:0];
          ent_st_tag[i]   <= bus.disp_st_tag_i;
          ent_st_rdy[i]   <= (bus.disp_st_tag_i == NO_VAL) || disp_st_hit[32];
          ent_st_val[i]   <= (bus.disp_st_tag_i == NO_VAL) ? bus.disp_st_val_i
                                                            : disp_st_hit[31:0];
        end else if (ent_valid[i]) begin
          if (do_pop && head_idx == AW'(i)) ent_valid[i] <= 1'b0;
          if (!ent_base_rdy[i] && base_hit[i][32]) begin
            ent_base_rdy[i] <= 1'b1;
            ent_base_val[i] <= base_hit[i][31:0];
          end
          if (ent_base_rdy[i] && !ent_addr_rdy[i]) begin
            ent_addr_rdy[i] <= 1'b1;
            ent_addr[i]     <= ent_base_val[i] + {{20{ent_off[i][11]}}, ent_off[i]};
          end
          if (!ent_st_rdy[i] && st_hit[i][32]) begin
            ent_st_rdy[i] <= 1'b1;
            ent_st_val[i] <= st_hit[i][31:0];
          end
        end
      end
    end
  end

  // Pointers, registered full flag, head aging and the post-pop hold register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      head_q      <= '0;
      tail_q      <= '0;
      full_q      <= 1'b0;
      head_age_q  <= 1'b0;
      hold_sel_q  <= 1'b0;
      hold_addr_q <= '0;
      hold_data_q <= '0;
    end else begin
      head_q     <= head_nxt;
      tail_q     <= tail_nxt;
      full_q     <= (tail_nxt - head_nxt) == DEPTH_C;
      // A fresh head (after a pop, or written into an empty queue) starts at age 0.
      head_age_q <= !do_pop && !empty;
      hold_sel_q <= do_pop;
      if (do_pop) begin
        hold_addr_q <= ent_addr[head_idx];
        hold_data_q <= ent_st_val[head_idx];
      end
    end
  end

  assign bus.lsq_full_o        = full_q;
  assign bus.lsq_count_o       = count;
  assign bus.lsu_empty_o       = empty;
  assign bus.lsu_instr_ready_o = ready;
  assign bus.lsu_load_o        = !empty && ent_load[head_idx];
  assign bus.lsu_ld_tag_o      = empty ? '0 : ent_ld_tag[head_idx];
  assign bus.lsu_eff_addr_o    = hold_sel_q ? hold_addr_q :
                                 (empty ? '0 : ent_addr[head_idx]);
  assign bus.lsu_st_data_o     = hold_sel_q ? hold_data_q :
                                 (empty ? '0 : ent_st_val[head_idx]);
endmodule

// File: tb/tb_load_store_queue.sv
// Bench for load_store_queue: directed corner sequences, an address table,
// and a randomized run scored against an in-order queue model.
module tb_load_store_queue;
  localparam int DEPTH = 8, NUM_CDB = 2, TAG_W = 5;

  typedef struct packed {
    logic [31:0] base;
    logic [11:0] off;
    logic [31:0] exp_addr;
  } vec_t;

  typedef struct packed {
    logic        load;
    logic [4:0]  ld_tag;
    logic [31:0] addr;
    logic [31:0] data;
  } rec_t;

  typedef struct packed {
    logic [4:0]  tag;
    logic [31:0] val;
  } pend_t;

  logic clk_i = 1'b0;
  logic reset_ni = 1'b1;
  int checks = 0;
  int errors = 0;

  rec_t  exp_q[$];
  pend_t pend_q[$];
  bit    tag_busy[32];
  vec_t  vecs[6];

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  load_store_queue_if #(.DEPTH(DEPTH), .NUM_CDB(NUM_CDB), .TAG_W(TAG_W)) bus ();

  load_store_queue #(.DEPTH(DEPTH), .NUM_CDB(NUM_CDB), .TAG_W(TAG_W)) dut (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .bus     (bus)
  );

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clr_in();
    bus.disp_valid_i    = 1'b0;
    bus.disp_load_i     = 1'b0;
    bus.disp_ld_tag_i   = '0;
    bus.disp_base_tag_i = '0;
    bus.disp_base_val_i = '0;
    bus.disp_offset_i   = '0;
    bus.disp_st_tag_i   = '0;
    bus.disp_st_val_i   = '0;
    bus.cdb_i           = '0;
    bus.lsu_read_i      = 1'b0;
  endtask

  task automatic drive_disp(input logic ld, input logic [4:0] ld_tag,
                            input logic [4:0] base_tag, input logic [31:0] base_val,
                            input logic [11:0] off, input logic [4:0] st_tag,
                            input logic [31:0] st_val);
    bus.disp_valid_i    = 1'b1;
    bus.disp_load_i     = ld;
    bus.disp_ld_tag_i   = ld_tag;
    bus.disp_base_tag_i = base_tag;
    bus.disp_base_val_i = base_val;
    bus.disp_offset_i   = off;
    bus.disp_st_tag_i   = st_tag;
    bus.disp_st_val_i   = st_val;
  endtask

  task automatic set_cdb(input int k, input logic [4:0] tag, input logic [31:0] val);
    bus.cdb_i[k] = {tag, val};
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!bus.lsu_instr_ready_o && n < 20) begin
      tick();
      n++;
    end
    chk(name, 32'(bus.lsu_instr_ready_o), 32'd1);
  endtask

  task automatic pop_one();
    bus.lsu_read_i = 1'b1;
    tick();
    bus.lsu_read_i = 1'b0;
  endtask

  function automatic logic [4:0] alloc_tag();
    logic [4:0] t;
    for (int n = 0; n < 64; n++) begin
      t = 5'($urandom_range(1, 31));
      if (!tag_busy[t]) begin
        tag_busy[t] = 1'b1;
        return t;
      end
    end
    for (int n = 1; n < 32; n++)
      if (!tag_busy[n]) begin
        tag_busy[n] = 1'b1;
        return 5'(n);
      end
    return 5'd0;
  endfunction

  // ---------------- stimulus + scoreboard ----------------
  initial begin
    logic        acc, popped, held_pending, rd;
    logic [4:0]  bt, st;
    logic [31:0] base_true, st_true;
    logic [11:0] off;
    rec_t        held_rec, nrec, front;
    int          op_id, idx;

    vecs[0] = '{base: 32'hFFFF_FFF0, off: 12'h020, exp_addr: 32'h0000_0010};
    vecs[1] = '{base: 32'h0000_1000, off: 12'hFFC, exp_addr: 32'h0000_0FFC};
    vecs[2] = '{base: 32'h0000_0000, off: 12'h7FF, exp_addr: 32'h0000_07FF};
    vecs[3] = '{base: 32'h0000_0000, off: 12'h800, exp_addr: 32'hFFFF_F800};
    vecs[4] = '{base: 32'h8000_0000, off: 12'hFFF, exp_addr: 32'h7FFF_FFFF};
    vecs[5] = '{base: 32'h1234_5678, off: 12'h001, exp_addr: 32'h1234_5679};

    clr_in();
    #2 reset_ni = 1'b0;
    #10;
    chk("rst_empty", 32'(bus.lsu_empty_o), 32'd1);
    chk("rst_ready", 32'(bus.lsu_instr_ready_o), 32'd0);
    chk("rst_full", 32'(bus.lsq_full_o), 32'd0);
    chk("rst_count", 32'(bus.lsq_count_o), 32'd0);
    chk("rst_load", 32'(bus.lsu_load_o), 32'd0);
    chk("rst_ld_tag", 32'(bus.lsu_ld_tag_o), 32'd0);
    chk("rst_addr", bus.lsu_eff_addr_o, 32'd0);
    chk("rst_data", bus.lsu_st_data_o, 32'd0);
    @(negedge clk_i) reset_ni = 1'b1;
    tick();

    // Reset in the middle of a stream
    for (int i = 0; i < 3; i++) begin
      drive_disp(1'b1, 5'(i + 1), 5'd0, 32'(32'h100 * i), 12'd0, 5'd0, 32'd0);
      tick();
    end
    clr_in();
    chk("t1_count3", 32'(bus.lsq_count_o), 32'd3);
    #2 reset_ni = 1'b0;
    #1;
    chk("t1_rst_empty", 32'(bus.lsu_empty_o), 32'd1);
    chk("t1_rst_ready", 32'(bus.lsu_instr_ready_o), 32'd0);
    chk("t1_rst_count", 32'(bus.lsq_count_o), 32'd0);
    #2 reset_ni = 1'b1;
    drive_disp(1'b1, 5'd7, 5'd0, 32'h40, 12'd4, 5'd0, 32'd0);
    tick();
    clr_in();
    chk("t1_count1", 32'(bus.lsq_count_o), 32'd1);
    tick();
    chk("t1_ready", 32'(bus.lsu_instr_ready_o), 32'd1);
    chk("t1_ld_tag", 32'(bus.lsu_ld_tag_o), 32'd7);
    chk("t1_addr", bus.lsu_eff_addr_o, 32'h44);
    pop_one();
    tick();
    chk("t1_empty", 32'(bus.lsu_empty_o), 32'd1);

    // Store waiting for its data on the CDB
    drive_disp(1'b0, 5'd0, 5'd0, 32'h1000, 12'hFFC, 5'd3, 32'd0);
    tick();
    clr_in();
    set_cdb(0, 5'd4, 32'h1111_1111);
    tick();
    clr_in();
    tick();
    chk("t2_wait_ready", 32'(bus.lsu_instr_ready_o), 32'd0);
    set_cdb(1, 5'd3, 32'hDEAD_BEEF);
    tick();
    clr_in();
    chk("t2_ready", 32'(bus.lsu_instr_ready_o), 32'd1);
    chk("t2_addr", bus.lsu_eff_addr_o, 32'h0000_0FFC);
    chk("t2_data", bus.lsu_st_data_o, 32'hDEAD_BEEF);
    chk("t2_load", 32'(bus.lsu_load_o), 32'd0);
    pop_one();
    tick();

    // Base captured from a CDB in the dispatch cycle
    drive_disp(1'b1, 5'd9, 5'd5, 32'h5555_5555, 12'd8, 5'd0, 32'd0);
    set_cdb(0, 5'd5, 32'h2000);
    tick();
    clr_in();
    chk("t3_ready_early", 32'(bus.lsu_instr_ready_o), 32'd0);
    tick();
    chk("t3_addr", bus.lsu_eff_addr_o, 32'h2008);
    chk("t3_ready", 32'(bus.lsu_instr_ready_o), 32'd1);
    chk("t3_ld_tag", 32'(bus.lsu_ld_tag_o), 32'd9);
    pop_one();
    tick();

    // Fill to full, refused dispatches
    for (int i = 0; i < DEPTH; i++) begin
      drive_disp(1'b1, 5'(i + 1), 5'd0, 32'(32'h100 * (i + 1)), 12'd0, 5'd0, 32'd0);
      tick();
    end
    clr_in();
    chk("t4_full", 32'(bus.lsq_full_o), 32'd1);
    chk("t4_count", 32'(bus.lsq_count_o), 32'd8);
    drive_disp(1'b1, 5'd30, 5'd0, 32'h0, 12'd0, 5'd0, 32'd0);
    tick();
    clr_in();
    chk("t4_ninth_ignored", 32'(bus.lsq_count_o), 32'd8);
    chk("t4_ready_full", 32'(bus.lsu_instr_ready_o), 32'd1);
    drive_disp(1'b1, 5'd20, 5'd0, 32'h0, 12'd0, 5'd0, 32'd0);
    bus.lsu_read_i = 1'b1;
    tick();
    clr_in();
    chk("t4_pop_disp_count", 32'(bus.lsq_count_o), 32'd7);
    chk("t4_full_clear", 32'(bus.lsq_full_o), 32'd0);
    for (int i = 2; i <= DEPTH; i++) begin
      wait_ready("t4_drain_ready");
      chk("t4_drain_tag", 32'(bus.lsu_ld_tag_o), 32'(i));
      pop_one();
    end
    tick();
    chk("t4_empty", 32'(bus.lsu_empty_o), 32'd1);

    // Hold register after a pop, fresh head not ready for one cycle
    drive_disp(1'b1, 5'd10, 5'd0, 32'h100, 12'd0, 5'd0, 32'd0);
    tick();
    drive_disp(1'b1, 5'd11, 5'd0, 32'h200, 12'd0, 5'd0, 32'd0);
    tick();
    clr_in();
    wait_ready("t5_ready_a");
    chk("t5_tag_a", 32'(bus.lsu_ld_tag_o), 32'd10);
    pop_one();
    chk("t5_held_addr", bus.lsu_eff_addr_o, 32'h100);
    chk("t5_tag_b", 32'(bus.lsu_ld_tag_o), 32'd11);
    chk("t5_ready_b_early", 32'(bus.lsu_instr_ready_o), 32'd0);
    tick();
    chk("t5_addr_b", bus.lsu_eff_addr_o, 32'h200);
    chk("t5_ready_b", 32'(bus.lsu_instr_ready_o), 32'd1);
    pop_one();
    tick();

    // Address table
    for (int i = 0; i < 6; i++) begin
      drive_disp(1'b1, 5'(i + 1), 5'd0, vecs[i].base, vecs[i].off, 5'd0, 32'd0);
      tick();
      clr_in();
      tick();
      chk("tab_ready", 32'(bus.lsu_instr_ready_o), 32'd1);
      chk("tab_addr", bus.lsu_eff_addr_o, vecs[i].exp_addr);
      pop_one();
      tick();
    end

    // Randomized run: in-order queue model, operands released at random times
    held_pending = 1'b0;
    held_rec = '0;
    op_id = 0;
    for (int c = 0; c < 32; c++) tag_busy[c] = 1'b0;
    for (int cyc = 0; cyc < 1100; cyc++) begin
      if (held_pending) begin
        chk("rnd_hold_addr", bus.lsu_eff_addr_o, held_rec.addr);
        if (!held_rec.load) chk("rnd_hold_data", bus.lsu_st_data_o, held_rec.data);
      end
      chk("rnd_count", 32'(bus.lsq_count_o), 32'(exp_q.size()));
      chk("rnd_full", 32'(bus.lsq_full_o), 32'(exp_q.size() == DEPTH));
      chk("rnd_empty", 32'(bus.lsu_empty_o), 32'(exp_q.size() == 0));
      clr_in();
      acc = 1'b0;
      if (cyc < 800 && $urandom_range(0, 9) < 6) begin
        acc = (exp_q.size() < DEPTH);
        base_true = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FF00 | 32'($urandom_range(0, 255)))
                                                : $urandom;
        off = 12'($urandom_range(0, 4095));
        st_true = $urandom;
        nrec.load = (op_id % 2 == 0);
        nrec.ld_tag = 5'($urandom_range(0, 31));
        nrec.addr = base_true + 32'($signed(off));
        nrec.data = st_true;
        bt = 5'd0;
        st = 5'd0;
        if (acc && $urandom_range(0, 1) == 1) begin
          bt = alloc_tag();
          pend_q.push_back('{tag: bt, val: base_true});
        end
        if (acc && !nrec.load && $urandom_range(0, 1) == 1) begin
          st = alloc_tag();
          pend_q.push_back('{tag: st, val: st_true});
        end
        drive_disp(nrec.load, nrec.ld_tag, bt, (bt != 0) ? ~base_true : base_true, off,
                   st, (st != 0) ? ~st_true : st_true);
      end
      rd = (cyc >= 800) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.lsu_read_i = rd;
      popped = rd && bus.lsu_instr_ready_o;
      if (popped) begin
        chk("rnd_pop_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          front = exp_q[0];
          chk("rnd_pop_tag", 32'(bus.lsu_ld_tag_o), 32'(front.ld_tag));
          chk("rnd_pop_load", 32'(bus.lsu_load_o), 32'(front.load));
        end
      end
      for (int k = 0; k < NUM_CDB; k++) begin
        if (pend_q.size() > 0 && (cyc >= 800 || $urandom_range(0, 9) < 4)) begin
          idx = $urandom_range(0, pend_q.size() - 1);
          set_cdb(k, pend_q[idx].tag, pend_q[idx].val);
          tag_busy[pend_q[idx].tag] = 1'b0;
          pend_q.delete(idx);
        end
      end
      tick();
      held_pending = 1'b0;
      if (popped && exp_q.size() != 0) begin
        held_rec = exp_q.pop_front();
        held_pending = 1'b1;
      end
      if (acc) begin
        exp_q.push_back(nrec);
        op_id++;
      end
    end
    clr_in();
    chk("rnd_drained", 32'(exp_q.size()), 32'd0);
    chk("rnd_final_count", 32'(bus.lsq_count_o), 32'd0);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
